aes_result_writer: RTL and testbench

//  Downstream stage of the AHB/RCU/AES core top level. Captures each 129-bit aes core

---
 rtl/aes_result_writer_pkg.sv | 21 ++
 rtl/aes_result_writer_if.sv | 33 +++
 rtl/aes_result_writer_result_fifo.sv | 59 +++++
 rtl/aes_result_writer.sv | 137 +++++++++++++
 tb/tb_aes_result_writer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_result_writer_pkg.sv
// Shared types and constants for the AES result writer: FSM encoding, block/word geometry.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int RESULT_W        = BLOCK_W + 1;
    localparam int ADDR_STEP       = WORD_W / 8;

    // Most significant word of a block; the writer shifts the block left so this is always current.
    function automatic logic [WORD_W-1:0] head_word(input logic [BLOCK_W-1:0] blk);
        return blk[BLOCK_W-1 -: WORD_W];
    endfunction

endpackage

// File: rtl/aes_result_writer_if.sv
// Bus bundle between the AES core / control unit, the result writer and the SRAM write port.
interface aes_result_writer_if #(
    parameter int ADDR_W = 32
);
    import aes_pkg::*;

    logic                clear;
    logic                addr_load;
    logic [ADDR_W-1:0]   addr_base;
    logic                aes_done;
    logic [RESULT_W-1:0] data_out;
    // sram_wen is the valid and sram_wack the ready: a word transfers on a cycle where both are
    // high, and sram_wen, sram_waddr and sram_wdata hold their values until that cycle.
    logic                sram_wen;
    logic [ADDR_W-1:0]   sram_waddr;
    logic [WORD_W-1:0]   sram_wdata;
    logic                sram_wack;
    logic                data_done;
    logic                last_done;
    logic                busy;
    logic                overflow;

    modport master (
        output clear, addr_load, addr_base, aes_done, data_out, sram_wack,
        input  sram_wen, sram_waddr, sram_wdata, data_done, last_done, busy, overflow
    );

    modport slave (
        input  clear, addr_load, addr_base, aes_done, data_out, sram_wack,
        output sram_wen, sram_waddr, sram_wdata, data_done, last_done, busy, overflow
    );

endinterface

// File: rtl/aes_result_writer_result_fifo.sv
// Small result FIFO with wrap-bit pointers; a push into a full FIFO is accepted when a pop
// happens in the same cycle, and the synchronous clear beats both.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/aes_result_writer.sv
// Captures AES core results into a FIFO and writes each 128-bit block to SRAM as four
// 32-bit words, most significant word first, pulsing data_done when a block is written back.
module aes_result_writer
    import aes_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    aes_result_writer_if.slave  bus,
    output wr_state_t           dbg_state_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLOCK - 1);

    wr_state_t            state_q, state_d;
    logic [BLOCK_W-1:0]   block_q, block_d;
    logic                 last_q, last_d;
    logic [1:0]           idx_q, idx_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic                 overflow_q, overflow_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [RESULT_W-1:0]  fifo_rdata;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty && !bus.clear;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.clear),
        .push_i  (bus.aes_done),
        .pop_i   (fifo_pop),
        .wdata_i (bus.data_out),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A result is dropped only when the FIFO is full and nothing leaves it this cycle.
    assign overflow_d = bus.clear ? 1'b0
                      : (overflow_q | (bus.aes_done && fifo_full && !fifo_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = WRITE;
                WRITE:   if (bus.sram_wack && (idx_q == LAST_IDX)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.sram_wen   = 1'b0;
        bus.sram_waddr = '0;
        bus.sram_wdata = '0;
        bus.data_done  = 1'b0;
        bus.last_done  = 1'b0;
        case (state_q)
            WRITE: begin
                bus.sram_wen   = 1'b1;
                bus.sram_waddr = ptr_q;
                bus.sram_wdata = head_word(block_q);
            end
            DONE: begin
                bus.data_done = 1'b1;
                bus.last_done = last_q;
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state_q != IDLE) || !fifo_empty;
    assign bus.overflow = overflow_q;
    assign dbg_state_o  = state_q;

    // Datapath next-state: pointer load/advance, block capture and word shifting.
    always_comb begin
        block_d = block_q;
        last_d  = last_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (!bus.clear) begin
            case (state_q)
                IDLE: begin
                    if (bus.addr_load) ptr_d = bus.addr_base;
                    if (!fifo_empty) begin
                        last_d  = fifo_rdata[RESULT_W-1];
                        block_d = fifo_rdata[BLOCK_W-1:0];
                        idx_d   = '0;
                    end
                end
                WRITE: begin
                    if (bus.sram_wack) begin
                        ptr_d   = ptr_q + ADDR_W'(ADDR_STEP);
                        block_d = {block_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                        idx_d   = idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_q    <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            block_q    <= block_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_aes_result_writer.sv
// Randomized bench for aes_result_writer: a transaction-level model turns each accepted
// result into four expected (address, word) writes plus one expected done/last event.
module tb_aes_result_writer;
    import aes_pkg::*;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    wr_state_t dbg_state;

    aes_result_writer_if #(.ADDR_W(ADDR_W)) bif ();

    aes_result_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bif),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [WORD_W-1:0] exp_data_q[$];
    logic              exp_last_q[$];
    logic [ADDR_W-1:0] model_ptr = '0;

    task automatic flush_model();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    // ---------------- sram_wack driver ----------------
    // 0: held low, 1: held high, 2: random, 3: follows wack_manual
    int   wack_mode   = 1;
    logic wack_manual = 1'b0;

    initial bif.sram_wack = 1'b0;
    always @(posedge clk) begin
        #1;
        case (wack_mode)
            0:       bif.sram_wack = 1'b0;
            1:       bif.sram_wack = 1'b1;
            2:       bif.sram_wack = ($urandom_range(0, 99) < 60);
            default: bif.sram_wack = wack_manual;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    int                wr_cnt        = 0;
    int                done_cnt      = 0;
    int                last_cnt      = 0;
    int                done_cyc      = 0;
    int                wen_start_cyc = 0;
    logic              prev_stall    = 1'b0;
    logic              prev_wen      = 1'b0;
    logic [ADDR_W-1:0] prev_addr     = '0;
    logic [WORD_W-1:0] prev_data     = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_wen   <= 1'b0;
        end else begin
            if (prev_stall && bif.sram_wen) begin
                check("hold_waddr", bif.sram_waddr, prev_addr);
                check("hold_wdata", bif.sram_wdata, prev_data);
            end
            if (bif.sram_wen && !prev_wen) wen_start_cyc <= cyc;
            if (bif.sram_wen && bif.sram_wack) begin
                wr_cnt <= wr_cnt + 1;
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", bif.sram_wen, 1'b0);
                end else begin
                    check("waddr", bif.sram_waddr, exp_addr_q.pop_front());
                    check("wdata", bif.sram_wdata, exp_data_q.pop_front());
                end
            end
            if (bif.data_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                if (bif.last_done) last_cnt <= last_cnt + 1;
                if (exp_last_q.size() == 0) check("unexpected_done", bif.data_done, 1'b0);
                else                         check("last_done", bif.last_done, exp_last_q.pop_front());
            end else if (bif.last_done) begin
                check("last_without_done", bif.last_done, bif.data_done);
            end
            prev_stall <= bif.sram_wen && !bif.sram_wack;
            prev_wen   <= bif.sram_wen;
            prev_addr  <= bif.sram_waddr;
            prev_data  <= bif.sram_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    int push_cyc = 0;

    task automatic load_addr(input logic [ADDR_W-1:0] base);
        @(posedge clk); #1;
        bif.addr_load = 1'b1;
        bif.addr_base = base;
        model_ptr     = base;
        @(posedge clk); #1;
        bif.addr_load = 1'b0;
    endtask

    // keep=0 marks a result the model expects the writer to drop.
    task automatic push_block(input logic last, input logic [BLOCK_W-1:0] blk, input bit keep);
        @(posedge clk); #1;
        bif.aes_done = 1'b1;
        bif.data_out = {last, blk};
        push_cyc     = cyc;
        if (keep) begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                exp_addr_q.push_back(model_ptr);
                exp_data_q.push_back(blk[BLOCK_W-1-WORD_W*w -: WORD_W]);
                model_ptr = model_ptr + ADDR_W'(4);
            end
            exp_last_q.push_back(last);
        end
        @(posedge clk); #1;
        bif.aes_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bif.busy && exp_last_q.size() == 0 && exp_addr_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check(tag, timed_out, 1'b0);
    endtask

    task automatic wait_wen();
        for (int i = 0; i < 50 && !bif.sram_wen; i++) @(negedge clk);
        check("wen_seen", bif.sram_wen, 1'b1);
    endtask

    function automatic logic [BLOCK_W-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int wr0;
        int dn0;
        int ls0;
        logic [ADDR_W-1:0] base;

        bif.clear     = 1'b0;
        bif.addr_load = 1'b0;
        bif.addr_base = '0;
        bif.aes_done  = 1'b0;
        bif.data_out  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_wen", bif.sram_wen, 1'b0);
        check("rst_waddr", bif.sram_waddr, '0);
        check("rst_wdata", bif.sram_wdata, '0);
        check("rst_done", bif.data_done, 1'b0);
        check("rst_last", bif.last_done, 1'b0);
        check("rst_busy", bif.busy, 1'b0);
        check("rst_ovf", bif.overflow, 1'b0);
        check("rst_state", dbg_state, IDLE);

        // single block, wack high: latency and word order
        wack_mode = 1;
        load_addr(32'h0000_0100);
        wr0 = wr_cnt; dn0 = done_cnt;
        push_block(1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        wait_idle("t1_drain");
        check("t1_wen_latency", wen_start_cyc - push_cyc, 2);
        check("t1_done_latency", done_cyc - push_cyc, 6);
        check("t1_writes", wr_cnt - wr0, 4);
        check("t1_dones", done_cnt - dn0, 1);

        // overflow: with wack low the first block parks in the writer, DEPTH more fill the
        // FIFO, so the next result has nowhere to go
        wack_mode = 0;
        repeat (2) @(posedge clk);
        wr0 = wr_cnt; dn0 = done_cnt;
        for (int i = 0; i < DEPTH + 1; i++) push_block(1'b0, rand_block(), 1'b1);
        @(negedge clk);
        check("t2_ovf_before", bif.overflow, 1'b0);
        push_block(1'b0, rand_block(), 1'b0);
        @(negedge clk);
        check("t2_ovf_after", bif.overflow, 1'b1);
        check("t2_busy", bif.busy, 1'b1);
        wack_mode = 1;
        wait_idle("t2_drain");
        check("t2_writes", wr_cnt - wr0, 4 * (DEPTH + 1));
        check("t2_dones", done_cnt - dn0, DEPTH + 1);
        check("t2_ovf_sticky", bif.overflow, 1'b1);
        @(posedge clk); #1 bif.clear = 1'b1;
        @(posedge clk); #1 bif.clear = 1'b0;
        @(negedge clk);
        check("t2_ovf_cleared", bif.overflow, 1'b0);

        // random data, random stalls, random gaps
        wack_mode = 2;
        base = {$urandom_range(0, 32'hFFFF), 16'h0} & 32'hFFFF_FFFC;
        load_addr(base);
        wr0 = wr_cnt; dn0 = done_cnt;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            for (int i = 0; i < 200 && exp_last_q.size() >= DEPTH; i++) @(posedge clk);
            push_block(1'($urandom_range(0, 1)), rand_block(), 1'b1);
        end
        wait_idle("t3_drain");
        check("t3_writes", wr_cnt - wr0, 120);
        check("t3_dones", done_cnt - dn0, 30);
        check("t3_no_ovf", bif.overflow, 1'b0);

        // address wrap, last flag
        wack_mode = 1;
        load_addr(32'hFFFF_FFF8);
        ls0 = last_cnt;
        push_block(1'b1, rand_block(), 1'b1);
        wait_idle("t4_drain");
        check("t4_ptr_model", model_ptr, 32'h0000_0008);
        check("t5_last_pulses", last_cnt - ls0, 1);

        // clear while word index 2 is pending
        wack_mode   = 3;
        wack_manual = 1'b0;
        base        = 32'h0000_2000;
        load_addr(base);
        dn0 = done_cnt;
        push_block(1'b0, rand_block(), 1'b1);
        wait_wen();
        wack_manual = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wack_manual = 1'b0;
        @(posedge clk); #1 bif.clear = 1'b1;
        @(negedge clk);
        check("t6_word2_addr", bif.sram_waddr, base + 32'd8);
        flush_model();
        model_ptr = base + 32'd8;
        @(posedge clk); #1 bif.clear = 1'b0;
        @(negedge clk);
        check("t6_wen_dropped", bif.sram_wen, 1'b0);
        check("t6_busy", bif.busy, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt - dn0, 0);
        // the pointer survives clear, so the next block continues at word 2's address
        wack_mode = 1;
        push_block(1'b0, rand_block(), 1'b1);
        wait_idle("t6_resume");

        // asynchronous reset mid-write
        wack_mode = 0;
        load_addr(32'h0000_3000);
        push_block(1'b0, rand_block(), 1'b1);
        wait_wen();
        #2 rst = 1'b1;
        #1;
        check("t7_wen", bif.sram_wen, 1'b0);
        check("t7_waddr", bif.sram_waddr, '0);
        check("t7_wdata", bif.sram_wdata, '0);
        check("t7_busy", bif.busy, 1'b0);
        check("t7_state", dbg_state, IDLE);
        flush_model();
        model_ptr = '0;
        @(posedge clk); #1 rst = 1'b0;
        wack_mode = 1;
        push_block(1'b0, rand_block(), 1'b1);
        wait_idle("t7_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
